veriyolu_par: RTL and testbench

VERIYOLU_PAR -- requirements
Module: veriyolu_par

---
 rtl/veriyolu_par.sv | 147 ++++++++++++++
 tb/tb_veriyolu_par.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veriyolu_par.sv
// veriyolu_par: small register-file engine with one outstanding memory access.
// Non-memory ops retire on the accept edge; LD/ST hold mem_req until mem_ack.
// Optional feature: define VERIYOLU_FLAGS_EN to add the 2-bit flags output
// ([0] zero, [1] carry/borrow), updated by ALU ops only.
//
// state | meaning
// IDLE  | cmd_ready=1; LDI/MOV/ALU complete here, LD/ST move to MEM
// MEM   | access outstanding; mem_req=1, commands and ack-less cycles wait
module veriyolu_par #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RW-1:0]    cmd_dst,
  input  logic [RW-1:0]    cmd_src,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  input  logic [RW-1:0]    dbg_sel,
`ifdef VERIYOLU_FLAGS_EN
  output logic [1:0]       flags,
`endif
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;
  localparam logic [2:0] OP_ST  = 3'd7;

  typedef enum logic {IDLE, MEM} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_regs [NREG];
  logic [RW-1:0]      r_dst;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_alu;
  logic               w_is_alu;
  logic               w_accept;

  assign w_a       = r_regs[cmd_dst];
  assign w_b       = r_regs[cmd_src];
  assign w_add     = w_a + w_b;
  assign w_sub     = w_a - w_b;
  assign w_is_alu  = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) ||
                     (cmd_op == OP_AND) || (cmd_op == OP_XOR);
  assign cmd_ready = (r_state == IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign dbg_data  = r_regs[dbg_sel];

  // ALU result selection; operands are the pre-edge register values
  always_comb begin
    w_alu = '0;
    case (cmd_op)
      OP_ADD:  w_alu = w_add;
      OP_SUB:  w_alu = w_sub;
      OP_AND:  w_alu = w_a & w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      default: w_alu = '0;
    endcase
  end

`ifdef VERIYOLU_FLAGS_EN
  logic [1:0] r_flags;
  logic       w_carry;

  assign flags = r_flags;

  // Modular wrap on ADD means a carry-out; SUB borrows when dst < src
  always_comb begin
    w_carry = 1'b0;
    case (cmd_op)
      OP_ADD:  w_carry = (w_add < w_a);
      OP_SUB:  w_carry = (w_a < w_b);
      default: w_carry = 1'b0;
    endcase
  end

  // Flags follow ALU ops only; LDI/MOV/LD/ST leave them untouched
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_flags <= 2'b00;
    end else if (w_accept && w_is_alu) begin
      r_flags <= {w_carry, (w_alu == '0)};
    end
  end
`endif

  // Control FSM, register file and registered memory-side outputs
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_state   <= IDLE;
      r_dst     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_LDI) begin
              r_regs[cmd_dst] <= cmd_imm;
            end else if (cmd_op == OP_MOV) begin
              r_regs[cmd_dst] <= w_b;
            end else if (w_is_alu) begin
              r_regs[cmd_dst] <= w_alu;
            end else begin
              mem_addr <= w_b;
              mem_we   <= (cmd_op == OP_ST);
              if (cmd_op == OP_ST) mem_wdata <= w_a;
              r_dst    <= cmd_dst;
              mem_req  <= 1'b1;
              r_state  <= MEM;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (!mem_we) r_regs[r_dst] <= mem_rdata;
            mem_req <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veriyolu_par.sv
// Bench for veriyolu_par: constant vector table, directed memory/reset
// sequences, then randomized commands against an arithmetic reference model.
`timescale 1ns/1ps
module tb_veriyolu_par;
  localparam int WIDTH = 8;
  localparam int NREG  = 4;
  localparam int RW    = 2;

  logic             aclk = 1'b0;
  logic             arst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [RW-1:0]    cmd_dst = '0;
  logic [RW-1:0]    cmd_src = '0;
  logic [WIDTH-1:0] cmd_imm = '0;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             mem_ack = 1'b0;
  logic [RW-1:0]    dbg_sel = '0;
  logic [WIDTH-1:0] dbg_data;
`ifdef VERIYOLU_FLAGS_EN
  logic [1:0]       flags;
`endif

  always #10 aclk = ~aclk;

  veriyolu_par #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_sel(dbg_sel),
`ifdef VERIYOLU_FLAGS_EN
    .flags(flags),
`endif
    .dbg_data(dbg_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m [NREG];
  logic [1:0] mf;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;

  typedef struct {
    logic [2:0] op;
    int         dst;
    int         src;
    logic [7:0] imm;
    logic [7:0] exp;
    logic [1:0] exp_flags;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [7:0] exp);
    logic [RW-1:0] s;
    s = idx[RW-1:0];
    dbg_sel = s;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic chk_all(input string name);
    for (int i = 0; i < NREG; i++) chk_reg(name, i, m[i]);
  endtask

  task automatic chk_flags(input string name, input logic [1:0] exp);
`ifdef VERIYOLU_FLAGS_EN
    chk(name, flags, exp);
`endif
  endtask

  task automatic drive(input logic [2:0] op, input int dst, input int src, input logic [7:0] imm);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst[RW-1:0];
    cmd_src   = src[RW-1:0];
    cmd_imm   = imm;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m[i] = 8'h00;
    mf = 2'b00;
    m_addr = 8'h00;
    m_wdata = 8'h00;
  endfunction

  // non-memory ops from plain arithmetic: flags = {carry, zero}
  function automatic void model_exec(input logic [2:0] op, input int dst, input int src, input logic [7:0] imm);
    int a, b, r;
    a = int'(m[dst]);
    b = int'(m[src]);
    case (op)
      3'd0: m[dst] = imm;
      3'd1: m[dst] = m[src];
      3'd2: begin r = a + b; m[dst] = 8'(r % 256); mf = {r > 255, (r % 256) == 0}; end
      3'd3: begin r = a - b; if (r < 0) r += 256; m[dst] = 8'(r); mf = {a < b, r == 0}; end
      3'd4: begin r = a & b; m[dst] = 8'(r); mf = {1'b0, r == 0}; end
      3'd5: begin r = a ^ b; m[dst] = 8'(r); mf = {1'b0, r == 0}; end
      default: ;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'd0, 1, 0, 8'h05, 8'h05, 2'b00};
    tbl[1]  = '{3'd0, 2, 0, 8'hFB, 8'hFB, 2'b00};
    tbl[2]  = '{3'd2, 1, 2, 8'h00, 8'h00, 2'b11};
    tbl[3]  = '{3'd0, 1, 0, 8'h03, 8'h03, 2'b11};
    tbl[4]  = '{3'd0, 2, 0, 8'h05, 8'h05, 2'b11};
    tbl[5]  = '{3'd3, 1, 2, 8'h00, 8'hFE, 2'b10};
    tbl[6]  = '{3'd1, 3, 1, 8'h00, 8'hFE, 2'b10};
    tbl[7]  = '{3'd4, 3, 2, 8'h00, 8'h04, 2'b00};
    tbl[8]  = '{3'd5, 3, 3, 8'h00, 8'h00, 2'b01};
    tbl[9]  = '{3'd0, 0, 0, 8'hAA, 8'hAA, 2'b01};
    tbl[10] = '{3'd2, 0, 0, 8'h00, 8'h54, 2'b10};
    tbl[11] = '{3'd3, 2, 2, 8'h00, 8'h00, 2'b01};

    // ---- asynchronous reset ----
    #3 arst = 1'b0;
    #1;
    model_reset();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_ready", cmd_ready, 1'b1);
    chk_flags("rst_flags", 2'b00);
    chk_all("rst_regs");
    @(negedge aclk);
    arst = 1'b1;
    @(negedge aclk);
    chk("ready_after_release", cmd_ready, 1'b1);

    // ---- vector table, issued back-to-back ----
    drive(tbl[0].op, tbl[0].dst, tbl[0].src, tbl[0].imm);
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      model_exec(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm);
      chk_reg($sformatf("tbl%0d_reg", i), tbl[i].dst, tbl[i].exp);
      chk($sformatf("tbl%0d_ready", i), cmd_ready, 1'b1);
      chk_flags($sformatf("tbl%0d_flags", i), tbl[i].exp_flags);
      if (i < 11) drive(tbl[i+1].op, tbl[i+1].dst, tbl[i+1].src, tbl[i+1].imm);
      else cmd_valid = 1'b0;
    end

    // ---- store with ack after 3 cycles ----
    @(negedge aclk);
    drive(3'd0, 0, 0, 8'h10);
    @(negedge aclk);
    model_exec(3'd0, 0, 0, 8'h10);
    drive(3'd0, 3, 0, 8'hA5);
    @(negedge aclk);
    model_exec(3'd0, 3, 0, 8'hA5);
    drive(3'd7, 3, 0, 8'h00);
    @(negedge aclk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge aclk);
      chk("st_req", mem_req, 1'b1);
      chk("st_ready", cmd_ready, 1'b0);
      chk("st_we", mem_we, 1'b1);
      chk("st_addr", mem_addr, 8'h10);
      chk("st_wdata", mem_wdata, 8'hA5);
    end
    mem_ack = 1'b1;
    @(negedge aclk);
    mem_ack = 1'b0;
    chk("st_done_req", mem_req, 1'b0);
    chk("st_done_ready", cmd_ready, 1'b1);
    chk("st_hold_addr", mem_addr, 8'h10);
    chk("st_hold_wdata", mem_wdata, 8'hA5);
    chk_all("st_regs");

    // ---- load with a command held pending during MEM ----
    drive(3'd6, 2, 0, 8'h00);
    @(negedge aclk);
    drive(3'd0, 1, 0, 8'h77);
    chk("ld_req", mem_req, 1'b1);
    chk("ld_ready", cmd_ready, 1'b0);
    chk("ld_we", mem_we, 1'b0);
    chk("ld_addr", mem_addr, 8'h10);
    chk("ld_wdata_hold", mem_wdata, 8'hA5);
    @(negedge aclk);
    chk_reg("ld_pending_r1", 1, m[1]);
    chk("ld_wait_req", mem_req, 1'b1);
    mem_rdata = 8'h3C;
    mem_ack = 1'b1;
    @(negedge aclk);
    mem_ack = 1'b0;
    m[2] = 8'h3C;
    chk_reg("ld_r2", 2, 8'h3C);
    chk("ld_done_ready", cmd_ready, 1'b1);
    chk("ld_done_req", mem_req, 1'b0);
    chk_reg("ld_r1_not_taken", 1, m[1]);
    @(negedge aclk);
    cmd_valid = 1'b0;
    model_exec(3'd0, 1, 0, 8'h77);
    chk_reg("held_ldi_r1", 1, 8'h77);

    // ---- stray ack in IDLE ----
    mem_rdata = 8'hFF;
    mem_ack = 1'b1;
    repeat (2) @(negedge aclk);
    mem_ack = 1'b0;
    chk("stray_req", mem_req, 1'b0);
    chk("stray_ready", cmd_ready, 1'b1);
    chk_all("stray_regs");

    // ---- reset pulse in the middle of MEM ----
    drive(3'd6, 1, 0, 8'h00);
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("mr_req_before", mem_req, 1'b1);
    #3 arst = 1'b0;
    #1;
    model_reset();
    chk("mr_req_drop", mem_req, 1'b0);
    chk("mr_ready", cmd_ready, 1'b1);
    chk("mr_addr", mem_addr, 8'h00);
    chk_all("mr_regs");
    @(negedge aclk);
    arst = 1'b1;
    @(negedge aclk);
    chk("mr_ready_release", cmd_ready, 1'b1);
    mem_rdata = 8'h5A;
    mem_ack = 1'b1;
    @(negedge aclk);
    mem_ack = 1'b0;
    chk("mr_late_ack_req", mem_req, 1'b0);
    chk_all("mr_late_ack_regs");

    // ---- randomized commands against the model ----
    for (int it = 0; it < 300; it++) begin
      logic [2:0] op;
      int d, s, w;
      logic [7:0] imm, rd;
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
        @(negedge aclk);
        mem_ack = 1'b0;
        chk("rnd_idle_req", mem_req, 1'b0);
      end
      op  = 3'($urandom_range(0, 7));
      d   = $urandom_range(0, NREG - 1);
      s   = $urandom_range(0, NREG - 1);
      imm = 8'($urandom);
      drive(op, d, s, imm);
      @(negedge aclk);
      cmd_valid = 1'b0;
      if (op < 3'd6) begin
        model_exec(op, d, s, imm);
        chk("rnd_req_low", mem_req, 1'b0);
        chk("rnd_ready", cmd_ready, 1'b1);
        chk("rnd_addr_hold", mem_addr, m_addr);
        chk_flags("rnd_flags", mf);
        chk_reg("rnd_reg", d, m[d]);
      end else begin
        m_addr = m[s];
        if (op == 3'd7) m_wdata = m[d];
        w = $urandom_range(0, 3);
        for (int k = 0; k <= w; k++) begin
          if (k > 0) @(negedge aclk);
          chk("rnd_mem_req", mem_req, 1'b1);
          chk("rnd_mem_ready", cmd_ready, 1'b0);
          chk("rnd_mem_we", mem_we, op == 3'd7);
          chk("rnd_mem_addr", mem_addr, m_addr);
          chk("rnd_mem_wdata", mem_wdata, m_wdata);
          drive(3'($urandom_range(0, 7)), $urandom_range(0, NREG - 1),
                $urandom_range(0, NREG - 1), 8'($urandom));
        end
        rd = 8'($urandom);
        mem_rdata = rd;
        mem_ack = 1'b1;
        @(negedge aclk);
        mem_ack = 1'b0;
        cmd_valid = 1'b0;
        if (op == 3'd6) m[d] = rd;
        chk("rnd_done_req", mem_req, 1'b0);
        chk("rnd_done_ready", cmd_ready, 1'b1);
        chk_flags("rnd_mem_flags", mf);
        chk_reg("rnd_mem_reg", d, m[d]);
      end
      if (it % 50 == 49) chk_all("rnd_all");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
